// File: rtl/touch_scan_ctrl.sv
// -----------------------------------------------------------------------------
// touch_scan_ctrl
//
// Autonomous scan controller for an ADS7843-type resistive touch ADC.
// It waits for pen-down, lets the panel settle, then runs batches of paired
// X/Y SPI conversions. It averages 2^AVG_LOG2 samples per axis and presents
// one coordinate pair with a single-clock valid pulse. While the pen stays
// down it repeats the batch every REPEAT_CYC clocks.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   enable     in   scan enable; a low level lets the current frame finish,
//                   then the controller returns to idle
//   pen_irq_n  in   panel pen interrupt (async, low = touched)
//   busy       in   ADC busy (async); only consulted before a frame starts
//   miso       in   SPI data from the ADC
//   mosi       out  SPI data to the ADC
//   sclk       out  SPI clock, idle low
//   ss_n       out  SPI chip select, active low
//   x_pos      out  averaged X result (held until the next report)
//   y_pos      out  averaged Y result (held until the next report)
//   pos_valid  out  one-clock pulse when x_pos/y_pos update
//   pen_down   out  high while a touch session is active
// -----------------------------------------------------------------------------
module touch_scan_ctrl #(
    parameter int CLK_DIV    = 25,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 50000,
    parameter int REPEAT_CYC = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pen_irq_n,
    input  logic        busy,
    input  logic        miso,
    output logic        mosi,
    output logic        sclk,
    output logic        ss_n,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        pos_valid,
    output logic        pen_down
);

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;

    localparam int WAIT_MAX = (SETTLE_CYC > REPEAT_CYC) ? SETTLE_CYC : REPEAT_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [WAIT_W-1:0] REPEAT_LAST = WAIT_W'(REPEAT_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [7:0]        DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [7:0]        DIV_SAMPLE  = 8'(CLK_DIV - 2);
    localparam logic [2:0]        PAIR_LAST   = 3'((1 << AVG_LOG2) - 1);

    // A frame is 50 half-phases of CLK_DIV clocks: phase 0 is the lead-in
    // with ss_n low, phases 1..48 are the 24 SCLK periods (odd = high),
    // phase 49 is the ss_n-high guard before anything else may start.
    localparam logic [5:0] PH_SS_RISE  = 6'd49;
    localparam logic [5:0] PH_CAP_LO   = 6'd18;
    localparam logic [5:0] PH_CAP_HI   = 6'd40;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAITBUSY = 3'd2,
        ST_FRAME    = 3'd3,
        ST_REPORT   = 3'd4,
        ST_HOLD     = 3'd5
    } state_t;

    // Command byte for the axis about to be converted.
    function automatic logic [7:0] axis_cmd(input logic is_y);
        logic [7:0] cmd;
        if (is_y) begin
            cmd = CMD_Y;
        end else begin
            cmd = CMD_X;
        end
        return cmd;
    endfunction

    logic              pen_meta_r;
    logic              pen_sync_r;
    logic              busy_meta_r;
    logic              busy_sync_r;
    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [7:0]        div_cnt_r;
    logic [5:0]        phase_r;
    logic [22:0]       cmd_sr_r;
    logic [11:0]       data_r;
    logic              axis_y_r;
    logic [2:0]        pair_cnt_r;
    logic [14:0]       acc_x_r;
    logic [14:0]       acc_y_r;
    logic              stop_r;

    logic [5:0]        phase_next_s;
    logic              div_wrap_s;
    logic              capture_s;
    logic [7:0]        frame_cmd_s;
    logic [11:0]       avg_x_s;
    logic [11:0]       avg_y_s;

    // Frame sequencing helpers and averaged results.
    always_comb begin
        phase_next_s = phase_r + 6'd1;
        div_wrap_s   = (div_cnt_r == DIV_LAST);
        frame_cmd_s  = axis_cmd(axis_y_r);
        avg_x_s      = 12'(acc_x_r >> AVG_LOG2);
        avg_y_s      = 12'(acc_y_r >> AVG_LOG2);
        // Sample one clock before the rising edges 10..21, which end the
        // even phases 18..40.
        if ((state_r == ST_FRAME) && (phase_r >= PH_CAP_LO) && (phase_r <= PH_CAP_HI) &&
            (phase_r[0] == 1'b0) && (div_cnt_r == DIV_SAMPLE)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Two-flop synchronizers for the asynchronous panel and ADC status lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pen_meta_r  <= 1'b1;
            pen_sync_r  <= 1'b1;
            busy_meta_r <= 1'b1;
            busy_sync_r <= 1'b1;
        end else begin
            pen_meta_r  <= pen_irq_n;
            pen_sync_r  <= pen_meta_r;
            busy_meta_r <= busy;
            busy_sync_r <= busy_meta_r;
        end
    end

    // Scan FSM with registered SPI pins, accumulators and results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            div_cnt_r  <= 8'd0;
            phase_r    <= 6'd0;
            cmd_sr_r   <= 23'd0;
            data_r     <= 12'd0;
            axis_y_r   <= 1'b0;
            pair_cnt_r <= 3'd0;
            acc_x_r    <= 15'd0;
            acc_y_r    <= 15'd0;
            stop_r     <= 1'b0;
            mosi       <= 1'b0;
            sclk       <= 1'b0;
            ss_n       <= 1'b1;
            x_pos      <= 12'd0;
            y_pos      <= 12'd0;
            pos_valid  <= 1'b0;
            pen_down   <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wait_cnt_r <= '0;
                    if (!pen_sync_r && enable) begin
                        pen_down <= 1'b1;
                        state_r  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (pen_sync_r || !enable) begin
                        pen_down   <= 1'b0;
                        wait_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else if (wait_cnt_r == SETTLE_LAST) begin
                        wait_cnt_r <= '0;
                        acc_x_r    <= 15'd0;
                        acc_y_r    <= 15'd0;
                        pair_cnt_r <= 3'd0;
                        axis_y_r   <= 1'b0;
                        state_r    <= ST_WAITBUSY;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end

                ST_WAITBUSY: begin
                    if (!enable) begin
                        pen_down <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (!busy_sync_r) begin
                        // Command bit 7 is on mosi as ss_n falls.
                        ss_n      <= 1'b0;
                        sclk      <= 1'b0;
                        mosi      <= frame_cmd_s[7];
                        cmd_sr_r  <= {frame_cmd_s[6:0], 16'd0};
                        div_cnt_r <= 8'd0;
                        phase_r   <= 6'd0;
                        data_r    <= 12'd0;
                        stop_r    <= 1'b0;
                        state_r   <= ST_FRAME;
                    end
                end

                ST_FRAME: begin
                    // Remember an enable drop so a short low pulse still ends the batch.
                    if (!enable) begin
                        stop_r <= 1'b1;
                    end
                    if (capture_s) begin
                        data_r <= {data_r[10:0], miso};
                    end
                    if (!div_wrap_s) begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end else begin
                        div_cnt_r <= 8'd0;
                        if (phase_r == PH_SS_RISE) begin
                            // Guard time over: bank the sample and pick what comes next.
                            phase_r <= 6'd0;
                            if (axis_y_r) begin
                                acc_y_r <= acc_y_r + {3'd0, data_r};
                            end else begin
                                acc_x_r <= acc_x_r + {3'd0, data_r};
                            end
                            if (stop_r || !enable) begin
                                pen_down <= 1'b0;
                                state_r  <= ST_IDLE;
                            end else if (!axis_y_r) begin
                                axis_y_r <= 1'b1;
                                state_r  <= ST_WAITBUSY;
                            end else if (pair_cnt_r == PAIR_LAST) begin
                                state_r <= ST_REPORT;
                            end else begin
                                pair_cnt_r <= pair_cnt_r + 3'd1;
                                axis_y_r   <= 1'b0;
                                state_r    <= ST_WAITBUSY;
                            end
                        end else if (phase_next_s == PH_SS_RISE) begin
                            phase_r <= phase_next_s;
                            ss_n    <= 1'b1;
                            sclk    <= 1'b0;
                            mosi    <= 1'b0;
                        end else begin
                            phase_r <= phase_next_s;
                            sclk    <= phase_next_s[0];
                            // Falling edge: advance to the next command bit.
                            if (!phase_next_s[0]) begin
                                mosi     <= cmd_sr_r[22];
                                cmd_sr_r <= {cmd_sr_r[21:0], 1'b0};
                            end
                        end
                    end
                end

                ST_REPORT: begin
                    wait_cnt_r <= '0;
                    if (!pen_sync_r) begin
                        x_pos     <= avg_x_s;
                        y_pos     <= avg_y_s;
                        pos_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else begin
                        pen_down <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    if (wait_cnt_r == REPEAT_LAST) begin
                        wait_cnt_r <= '0;
                        if (!pen_sync_r && enable) begin
                            acc_x_r    <= 15'd0;
                            acc_y_r    <= 15'd0;
                            pair_cnt_r <= 3'd0;
                            axis_y_r   <= 1'b0;
                            state_r    <= ST_WAITBUSY;
                        end else begin
                            pen_down <= 1'b0;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end

                default: begin
                    ss_n     <= 1'b1;
                    sclk     <= 1'b0;
                    mosi     <= 1'b0;
                    pen_down <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/touch_scan_ctrl.md
Name: touch_scan_ctrl

Overview:
- Autonomous scan controller for the resistive touch panel ADC (ADS7843-type, SPI) on the LT24 board.
- Detects pen-down on the pen interrupt and runs paired X/Y SPI conversions.
- Averages 2^AVG_LOG2 samples per axis and presents one coordinate pair with a valid pulse.
- Replaces software-driven polling of the SPI peripheral. Sits between the panel pins and the Avalon CSR wrapper that the Nios reads.

Parameters:
- CLK_DIV, 25: system clocks per SCLK half-period (50 MHz gives 1 MHz SCLK); legal range 2..255.
- AVG_LOG2, 2: log2 of samples per axis per report; legal range 0..3.
- SETTLE_CYC, 50000: clocks to wait after pen-down detection before the first frame (1 ms).
- REPEAT_CYC, 500000: clocks between report batches while the pen stays down (10 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scan enable; when low, finish the current frame, then go to IDLE
- pen_irq_n  in  1  panel pen interrupt, asynchronous, low = touched
- busy  in  1  ADC busy, asynchronous
- miso  in  1  SPI data from ADC
- mosi  out  1  SPI data to ADC
- sclk  out  1  SPI clock, idle low
- ss_n  out  1  SPI chip select, active low
- x_pos  out  12  averaged X result
- y_pos  out  12  averaged Y result
- pos_valid  out  1  one-clock pulse when x_pos/y_pos update
- pen_down  out  1  high while a touch session is active

Behaviour:
- Reset values: mosi=0, sclk=0, ss_n=1, x_pos=0, y_pos=0, pos_valid=0, pen_down=0. FSM state is IDLE; all counters and accumulators are 0.
- pen_irq_n and busy each pass through a 2-flop synchronizer; miso is sampled directly.
- State IDLE: go to SETTLE when synced pen_irq_n=0 and enable=1. pen_down is set on entering SETTLE.
- State SETTLE: count SETTLE_CYC clocks. If pen_irq_n is synced high before the count completes, return to IDLE and clear pen_down.
- State WAITBUSY: wait for synced busy=0, then start a frame.
- Frame timing:
  - ss_n falls; CLK_DIV clocks later comes the first SCLK rising edge. There are 24 SCLK periods with high and low each CLK_DIV clocks.
  - ss_n rises CLK_DIV clocks after the 24th falling edge. It then stays high at least CLK_DIV clocks before the next frame.
- Command bits: mosi presents command bit 7 at ss_n fall. Each following bit changes at the SCLK falling edge. Bits 8..23 of mosi are 0.
- Commands: X = 0xD0, Y = 0x90 (12-bit, differential, PD=00).
- Data capture: miso is sampled one clock before each SCLK rising edge, on rising edges 10..21 (1-indexed). These 12 bits form the sample, MSB first.
- Batch order: X frame, Y frame, repeated 2^AVG_LOG2 times.
- Accumulators are 15 bits per axis; no overflow is possible.
- State REPORT: one clock, entered after the last Y frame.
  - If synced pen_irq_n=0: x_pos = acc_x >> AVG_LOG2 (truncating) and y_pos likewise; pos_valid=1 for that clock.
  - Otherwise the batch is discarded, pen_down clears, and the FSM goes to IDLE with no pos_valid.
- Accumulators clear on entry to each batch.
- State HOLD: count REPEAT_CYC clocks, then start a new batch (via WAITBUSY) if pen_irq_n=0 and enable=1. Otherwise clear pen_down and go to IDLE.
- enable drop mid-batch: the current frame completes with full SCLK/ss_n timing, then the FSM goes to IDLE. No pos_valid; pen_down clears.
- pen_irq_n is ignored during frames; the ADC may hold it.
- busy is only checked in WAITBUSY.
- Asynchronous reset mid-frame: all outputs return to reset values immediately; ss_n=1 and sclk=0 with no glitch beyond the reset edge.
- x_pos/y_pos hold their last reported values until the next REPORT.

Test Plan:
- Reset asserted mid-frame (ss_n=0) -> ss_n=1, sclk=0, pen_down=0, pos_valid=0 within the reset assertion; no further SCLK until a new pen-down.
- Pen-down held, AVG_LOG2=0, ADC model returns X=0xA5C, Y=0x3F1 -> ss_n low for 24 SCLK periods per frame, SCLK period 50 clocks; mosi shifts 0xD0 then 0x90; one pos_valid with x_pos=0xA5C, y_pos=0x3F1.
- AVG_LOG2=2, X samples 100,101,102,104, Y all 4095 -> x_pos=101 (407>>2), y_pos=4095, exactly one pos_valid per batch; next batch starts REPEAT_CYC clocks later.
- Pen released during SETTLE (pen_irq_n high at clock 1000) -> no frame, pen_down=0, back to IDLE.
- Pen released during a batch -> batch completes, no pos_valid, pen_down=0, x_pos/y_pos retain prior values.
- busy held high for 300 clocks before a frame -> ss_n stays high until 2 clocks after busy falls (synchronizer); enable low mid-frame -> the frame finishes its 24 SCLKs, then IDLE, no pos_valid.
